// File: rtl/mac_pkg.sv
// Shared definitions for the MAC frame engine: FSM state encodings and
// elaboration-time parameter checks.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_e;

    // Accumulator must hold at least one full-width product.
    function automatic bit acc_w_ok(input int unsigned data_w, input int unsigned acc_w);
        return acc_w >= 2 * data_w;
    endfunction

endpackage

// File: rtl/mac_frame_engine_if.sv
// Operand/control/result bundle between the operand source, the MAC frame
// engine and the result consumer.
interface mac_frame_engine_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned LEN    = 10
);
    localparam int unsigned CNT_W = $clog2(LEN + 1);

    logic                  go;
    logic                  abort;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [2*DATA_W-1:0]   prod_out;
    logic [ACC_W-1:0]      sum_out;
    logic [CNT_W-1:0]      count_out;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport master (
        output go, abort, in_valid, a, b,
        input  in_ready, prod_out, sum_out, count_out, busy, done, overflow
    );

    modport slave (
        input  go, abort, in_valid, a, b,
        output in_ready, prod_out, sum_out, count_out, busy, done, overflow
    );

endinterface

// File: rtl/mac_mult_stage.sv
// Registered multiplier with enable and synchronous clear; operands are
// sign- or zero-extended to the full product width before multiplying.
module mac_mult_stage #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod,
    output logic                  vld
);
    localparam int unsigned PW = 2 * DATA_W;

    logic [PW-1:0] a_x, b_x;
    logic [PW-1:0] prod_d, prod_q;
    logic          vld_d, vld_q;

    // Truncated product of extended operands is exact in two's complement.
    always_comb begin
        a_x    = {{DATA_W{(SIGNED != 0) && a[DATA_W-1]}}, a};
        b_x    = {{DATA_W{(SIGNED != 0) && b[DATA_W-1]}}, b};
        prod_d = prod_q;
        vld_d  = en;
        if (clr) begin
            prod_d = '0;
            vld_d  = 1'b0;
        end else if (en) begin
            prod_d = a_x * b_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
        end
    end

    assign prod = prod_q;
    assign vld  = vld_q;

endmodule

// File: rtl/mac_frame_engine.sv
// Frame-based multiply-accumulate engine: accepts LEN operand pairs after go,
// pulses done with the final sum. MAC_SAT_EN selects saturating accumulation.
module mac_frame_engine
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned LEN    = 10,
    parameter int unsigned SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mac_frame_engine_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(LEN + 1);
    localparam int unsigned PW    = 2 * DATA_W;

    if (!acc_w_ok(DATA_W, ACC_W)) begin : g_bad_acc_w
        $error("mac_frame_engine: ACC_W must be >= 2*DATA_W");
    end
    if (LEN < 1) begin : g_bad_len
        $error("mac_frame_engine: LEN must be >= 1");
    end

    mac_state_e        state_d, state_q;
    logic [CNT_W-1:0]  count_d, count_q;
    logic [ACC_W-1:0]  sum_d, sum_q, sum_nx;
    logic              ovf_d, ovf_q;
    logic [DATA_W-1:0] a_d, a_q, b_d, b_q;
    logic              v0_d, v0_q;
    logic              in_ready_d, in_ready_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              start, accept, step_ovf;
    logic [PW-1:0]     prod;
    logic              prod_vld;
    logic [ACC_W:0]    sum_x, prod_x, add_x;
`ifdef MAC_SAT_EN
    logic [ACC_W-1:0]  sat_v;
`endif

    mac_mult_stage #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (v0_q & ~bus.abort),
        .a     (a_q),
        .b     (b_q),
        .prod  (prod),
        .vld   (prod_vld)
    );

    // Next sum: one extra bit catches carry-out (unsigned) or sign flip (signed).
    always_comb begin
        sum_x  = {(SIGNED != 0) && sum_q[ACC_W-1], sum_q};
        prod_x = {{(ACC_W + 1 - PW){(SIGNED != 0) && prod[PW-1]}}, prod};
        add_x  = sum_x + prod_x;
        if (SIGNED != 0) step_ovf = add_x[ACC_W] ^ add_x[ACC_W-1];
        else             step_ovf = add_x[ACC_W];
`ifdef MAC_SAT_EN
        if (SIGNED != 0)
            sat_v = add_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_v = '1;
        sum_nx = step_ovf ? sat_v : add_x[ACC_W-1:0];
`else
        sum_nx = add_x[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        v0_d    = 1'b0;
        start   = 1'b0;
        accept  = bus.in_valid & in_ready_q & ~bus.abort;

        case (state_q)
            ST_IDLE: if (bus.go && !bus.abort) begin
                start   = 1'b1;
                state_d = ST_RUN;
                count_d = '0;
                sum_d   = '0;
                ovf_d   = 1'b0;
            end
            ST_RUN:   if (count_q == CNT_W'(LEN)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            count_d = count_q + CNT_W'(1);
            a_d     = bus.a;
            b_d     = bus.b;
            v0_d    = 1'b1;
        end

        if (prod_vld && !bus.abort) begin
            sum_d = sum_nx;
            ovf_d = ovf_q | step_ovf;
        end

        // Abort freezes partial results and drops any in-flight products.
        if (bus.abort) state_d = ST_IDLE;

        in_ready_d = (state_d == ST_RUN) && (count_d < CNT_W'(LEN));
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            v0_q       <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            a_q        <= a_d;
            b_q        <= b_d;
            v0_q       <= v0_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.prod_out  = prod;
    assign bus.sum_out   = sum_q;
    assign bus.count_out = count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mac_frame_engine.sv
// Self-checking bench for mac_frame_engine: four parameter variants driven one
// at a time, results compared against an arithmetic frame model.
module tb_mac_frame_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int         sel = 0;
    logic       go_i = 1'b0, abort_i = 1'b0, valid_i = 1'b0;
    logic [3:0] a_i = '0, b_i = '0;

    int errors = 0;
    int checks = 0;

    int len_of  [4] = '{10, 20, 10, 10};
    int accw_of [4] = '{12, 12, 12, 8};
    int sgn_of  [4] = '{0, 0, 1, 1};
    int av [32];
    int bv [32];

    mac_frame_engine_if #(.DATA_W(4), .ACC_W(12), .LEN(10)) if0 ();
    mac_frame_engine_if #(.DATA_W(4), .ACC_W(12), .LEN(20)) if1 ();
    mac_frame_engine_if #(.DATA_W(4), .ACC_W(12), .LEN(10)) if2 ();
    mac_frame_engine_if #(.DATA_W(4), .ACC_W(8),  .LEN(10)) if3 ();

    assign if0.go = go_i && (sel == 0);  assign if0.abort = abort_i && (sel == 0);
    assign if1.go = go_i && (sel == 1);  assign if1.abort = abort_i && (sel == 1);
    assign if2.go = go_i && (sel == 2);  assign if2.abort = abort_i && (sel == 2);
    assign if3.go = go_i && (sel == 3);  assign if3.abort = abort_i && (sel == 3);
    assign if0.in_valid = valid_i && (sel == 0);  assign if0.a = a_i;  assign if0.b = b_i;
    assign if1.in_valid = valid_i && (sel == 1);  assign if1.a = a_i;  assign if1.b = b_i;
    assign if2.in_valid = valid_i && (sel == 2);  assign if2.a = a_i;  assign if2.b = b_i;
    assign if3.in_valid = valid_i && (sel == 3);  assign if3.a = a_i;  assign if3.b = b_i;

    mac_frame_engine #(.DATA_W(4), .ACC_W(12), .LEN(10), .SIGNED(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mac_frame_engine #(.DATA_W(4), .ACC_W(12), .LEN(20), .SIGNED(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mac_frame_engine #(.DATA_W(4), .ACC_W(12), .LEN(10), .SIGNED(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mac_frame_engine #(.DATA_W(4), .ACC_W(8),  .LEN(10), .SIGNED(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic        o_ready, o_busy, o_done, o_ovf;
    logic [7:0]  o_prod;
    logic [11:0] o_sum;
    logic [4:0]  o_cnt;

    always_comb begin
        o_ready = 1'b0; o_busy = 1'b0; o_done = 1'b0; o_ovf = 1'b0;
        o_prod = '0; o_sum = '0; o_cnt = '0;
        case (sel)
            0: begin o_ready = if0.in_ready; o_busy = if0.busy; o_done = if0.done; o_ovf = if0.overflow;
                     o_prod = if0.prod_out; o_sum = if0.sum_out; o_cnt = 5'(if0.count_out); end
            1: begin o_ready = if1.in_ready; o_busy = if1.busy; o_done = if1.done; o_ovf = if1.overflow;
                     o_prod = if1.prod_out; o_sum = if1.sum_out; o_cnt = if1.count_out; end
            2: begin o_ready = if2.in_ready; o_busy = if2.busy; o_done = if2.done; o_ovf = if2.overflow;
                     o_prod = if2.prod_out; o_sum = if2.sum_out; o_cnt = 5'(if2.count_out); end
            default: begin o_ready = if3.in_ready; o_busy = if3.busy; o_done = if3.done; o_ovf = if3.overflow;
                     o_prod = if3.prod_out; o_sum = 12'(if3.sum_out); o_cnt = 5'(if3.count_out); end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame result from plain integer arithmetic over the first n pairs.
    task automatic model(input int inst, input int n, output int e_sum, output int e_prod, output int e_ovf);
        int w, lo, hi, exact, acc, p, sa, sb;
        w = accw_of[inst];
        if (sgn_of[inst] != 0) begin lo = -(1 << (w - 1)); hi = (1 << (w - 1)) - 1; end
        else begin lo = 0; hi = (1 << w) - 1; end
        exact = 0; acc = 0; p = 0; e_ovf = 0;
        for (int i = 0; i < n; i++) begin
            sa = av[i]; sb = bv[i];
            if (sgn_of[inst] != 0 && sa >= 8) sa -= 16;
            if (sgn_of[inst] != 0 && sb >= 8) sb -= 16;
            p = sa * sb;
            exact += p;
            if (exact < lo || exact > hi) e_ovf = 1;
`ifdef MAC_SAT_EN
            acc += p;
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
`else
            acc = exact;
`endif
        end
        e_sum  = acc & ((1 << w) - 1);
        e_prod = p & 255;
    endtask

    task automatic run_frame(input int inst, input int gap, input int abort_idx, input bit extra_go, input string tag);
        int len, idx, gapcnt, cyc, last_acc, done_cyc, dones, early;
        int e_sum, e_prod, e_ovf;
        bit stop, fire, ab;
        logic [11:0] s_sum; logic [7:0] s_prod; logic [4:0] s_cnt; logic s_ovf, s_busy, s_ready;
        len = len_of[inst]; idx = 0; gapcnt = 0; cyc = 0; last_acc = -100; done_cyc = -1;
        dones = 0; early = 0; stop = 0;
        s_sum = '0; s_prod = '0; s_cnt = '0; s_ovf = 1'b0; s_busy = 1'b1; s_ready = 1'b1;
        sel = inst;
        #1;
        while (cyc < 3000 && !stop) begin
            go_i    = (cyc < 3) || (extra_go && idx == 4);
            valid_i = (idx < len) && (gapcnt == 0);
            a_i     = 4'(av[idx]);
            b_i     = 4'(bv[idx]);
            abort_i = (idx == abort_idx) && valid_i && o_ready;
            fire    = valid_i && o_ready && !abort_i;
            ab      = abort_i;
            @(posedge clk); #1;
            cyc++;
            abort_i = 1'b0;
            if (fire) begin idx++; gapcnt = gap; last_acc = cyc; end
            else if (!valid_i && gapcnt > 0) gapcnt--;
            if (ab) stop = 1;
            if (o_busy && o_cnt < 5'(len) && !o_ready) early++;
            if (o_done) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = cyc; s_sum = o_sum; s_prod = o_prod; s_cnt = o_cnt;
                    s_ovf = o_ovf; s_busy = o_busy; s_ready = o_ready;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) stop = 1;
        end
        go_i = 1'b0; valid_i = 1'b0;
        if (abort_idx >= 0) begin
            chk({tag, ".busy"},  32'(o_busy), 0);
            chk({tag, ".ready"}, 32'(o_ready), 0);
            chk({tag, ".count"}, 32'(o_cnt), 32'(abort_idx));
            repeat (4) begin @(posedge clk); #1; if (o_done) dones++; end
            chk({tag, ".no_done"}, 32'(dones), 0);
        end else begin
            model(inst, len, e_sum, e_prod, e_ovf);
            chk({tag, ".dones"},   32'(dones), 1);
            chk({tag, ".latency"}, 32'(done_cyc - last_acc), 2);
            chk({tag, ".sum"},     32'(s_sum), 32'(e_sum));
            chk({tag, ".prod"},    32'(s_prod), 32'(e_prod));
            chk({tag, ".count"},   32'(s_cnt), 32'(len));
            chk({tag, ".ovf"},     32'(s_ovf), 32'(e_ovf));
            chk({tag, ".busy_at_done"},  32'(s_busy), 0);
            chk({tag, ".ready_at_done"}, 32'(s_ready), 0);
            chk({tag, ".early_ready_drop"}, 32'(early), 0);
            chk({tag, ".sum_hold"}, 32'(o_sum), 32'(e_sum));
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 32; i++) begin av[i] = i & 15; bv[i] = (2 * i + 1) & 15; end
    endtask

    initial begin
        int k, guard;
        bit f;

        repeat (3) @(posedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            chk("reset.busy",  32'(o_busy), 0);
            chk("reset.done",  32'(o_done), 0);
            chk("reset.ready", 32'(o_ready), 0);
            chk("reset.sum",   32'(o_sum), 0);
            chk("reset.cnt",   32'(o_cnt), 0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        load_ramp();
        run_frame(0, 0, -1, 0, "ramp");
        run_frame(0, 3, -1, 0, "ramp_gap3");

        for (int i = 0; i < 32; i++) begin av[i] = 15; bv[i] = 15; end
        run_frame(1, 0, -1, 0, "len20_ovf");

        for (int i = 0; i < 32; i++) begin av[i] = 8; bv[i] = 7; end
        run_frame(2, 1, -1, 0, "signed_neg");

        // Asynchronous reset in the middle of a frame.
        load_ramp();
        sel = 0; k = 0; guard = 0; go_i = 1'b1;
        while (k < 5 && guard < 100) begin
            valid_i = 1'b1; a_i = 4'(av[k]); b_i = 4'(bv[k]);
            f = o_ready;
            @(posedge clk); #1;
            if (f) k++;
            guard++;
        end
        chk("rst_mid.accepts", 32'(k), 5);
        rst_n = 1'b0; go_i = 1'b0; valid_i = 1'b0;
        #2;
        chk("rst_mid.sum",   32'(o_sum), 0);
        chk("rst_mid.prod",  32'(o_prod), 0);
        chk("rst_mid.cnt",   32'(o_cnt), 0);
        chk("rst_mid.busy",  32'(o_busy), 0);
        chk("rst_mid.ready", 32'(o_ready), 0);
        chk("rst_mid.ovf",   32'(o_ovf), 0);
        k = 0;
        repeat (3) begin @(posedge clk); #1; if (o_done) k++; end
        chk("rst_mid.no_done", 32'(k), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 0, -1, 0, "after_reset");

        run_frame(0, 0, 5, 0, "abort");
        run_frame(0, 0, -1, 1, "go_in_run");

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 32; i++) begin av[i] = int'($urandom_range(0, 15)); bv[i] = int'($urandom_range(0, 15)); end
            run_frame(r % 4, int'($urandom_range(0, 2)), -1, (r % 3) == 0, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
